pacman_game_monitor: RTL and testbench

Downstream scoreboard/referee stage for the Pac-Man game core. It consumes the core's candy map, Pac-Man position and sticky catch flag, and runs the game-session state machine (idle, playing, won, lost). It also keeps the score, the remaining-candy count and the step count, and enforces a step-limit timeout. Its outputs drive the display/HUD logic and the game-restart control.

---
 rtl/pacman_game_monitor_if.sv | 34 +++
 rtl/pacman_game_monitor.sv | 141 ++++++++++++++
 tb/tb_pacman_game_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pacman_game_monitor_if.sv
// Bundle between the Pac-Man game core, the session monitor and the HUD.
// The master modport is the core/HUD side; the slave modport is the monitor.
interface pacman_game_monitor_if #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int SCORE_W = 10,
    parameter int STEP_W  = 8
) ();
    localparam int CW = $clog2(WIDTH*HEIGHT+1);

    logic                          start;
    logic [WIDTH-1:0]              pacman_x;
    logic [HEIGHT-1:0]             pacman_y;
    logic [WIDTH-1:0][HEIGHT-1:0]  candies;
    logic                          catch;
    logic [1:0]                    state;
    logic [SCORE_W-1:0]            score;
    logic [CW-1:0]                 candies_left;
    logic [STEP_W-1:0]             steps;
    logic                          won;
    logic                          lost;
    logic                          timeout;
    logic                          game_over;

    modport master (
        output start, pacman_x, pacman_y, candies, catch,
        input  state, score, candies_left, steps, won, lost, timeout, game_over
    );

    modport slave (
        input  start, pacman_x, pacman_y, candies, catch,
        output state, score, candies_left, steps, won, lost, timeout, game_over
    );
endinterface

// File: rtl/pacman_game_monitor.sv
// Game-session referee: tracks score, remaining candies and steps, and runs
// the idle/play/won/lost session state machine with a step-limit timeout.
module pacman_game_monitor #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int SCORE_W   = 10,
    parameter int CANDY_PTS = 10,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    pacman_game_monitor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH*HEIGHT+1);
    localparam int PW = SCORE_W + CW;
    localparam logic [PW:0] SCORE_MAX = (PW+1)'((2**SCORE_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WON  = 2'b10,
        S_LOST = 2'b11
    } state_t;

    state_t              state_reg, state_next;
    logic [SCORE_W-1:0]  score_reg, score_next;
    logic [STEP_W-1:0]   steps_reg, steps_next;
    logic                timeout_reg, timeout_next;
    logic [CW-1:0]       prev_count_reg, prev_count_next;
    logic [WIDTH-1:0]    prev_x_reg, prev_x_next;
    logic [HEIGHT-1:0]   prev_y_reg, prev_y_next;
    logic [CW-1:0]       left_reg;
    logic                won_reg, lost_reg, over_reg;

    logic [CW-1:0]       cur_count;
    logic [CW-1:0]       delta;
    logic [PW-1:0]       award;
    logic [PW:0]         sum;
    logic [SCORE_W-1:0]  score_award;
    logic [STEP_W-1:0]   steps_inc;
    logic                moved;

    always_comb begin
        cur_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < HEIGHT; j++) begin
                cur_count = cur_count + CW'(bus.candies[i][j]);
            end
        end
    end

    // Only a drop in the candy count scores; a map reload earns nothing.
    always_comb begin
        delta       = (cur_count < prev_count_reg) ? (prev_count_reg - cur_count) : '0;
        award       = PW'(delta) * PW'(CANDY_PTS);
        sum         = (PW+1)'(score_reg) + (PW+1)'(award);
        score_award = (sum > SCORE_MAX) ? '1 : SCORE_W'(sum);
    end

    assign moved     = ({bus.pacman_x, bus.pacman_y} != {prev_x_reg, prev_y_reg});
    assign steps_inc = steps_reg + STEP_W'(1);

    always_comb begin
        state_next      = state_reg;
        score_next      = score_reg;
        steps_next      = steps_reg;
        timeout_next    = timeout_reg;
        prev_count_next = prev_count_reg;
        prev_x_next     = prev_x_reg;
        prev_y_next     = prev_y_reg;
        case (state_reg)
            S_PLAY: begin
                score_next      = score_award;
                prev_count_next = cur_count;
                prev_x_next     = bus.pacman_x;
                prev_y_next     = bus.pacman_y;
                if (moved) steps_next = steps_inc;
                // Catch beats the last candy, which beats the step limit.
                if (bus.catch) begin
                    state_next   = S_LOST;
                    timeout_next = 1'b0;
                end else if (cur_count == '0) begin
                    state_next = S_WON;
                end else if (moved && (steps_inc == STEP_W'(MAX_STEPS))) begin
                    state_next   = S_LOST;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    state_next      = S_PLAY;
                    score_next      = '0;
                    steps_next      = '0;
                    timeout_next    = 1'b0;
                    prev_count_next = cur_count;
                    prev_x_next     = bus.pacman_x;
                    prev_y_next     = bus.pacman_y;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            score_reg      <= '0;
            steps_reg      <= '0;
            timeout_reg    <= 1'b0;
            prev_count_reg <= '0;
            prev_x_reg     <= '0;
            prev_y_reg     <= '0;
            left_reg       <= '0;
            won_reg        <= 1'b0;
            lost_reg       <= 1'b0;
            over_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            score_reg      <= score_next;
            steps_reg      <= steps_next;
            timeout_reg    <= timeout_next;
            prev_count_reg <= prev_count_next;
            prev_x_reg     <= prev_x_next;
            prev_y_reg     <= prev_y_next;
            left_reg       <= cur_count;
            // Status flags get their own flops so the HUD never sees decode glitches.
            won_reg        <= (state_next == S_WON);
            lost_reg       <= (state_next == S_LOST);
            over_reg       <= (state_next == S_WON) || (state_next == S_LOST);
        end
    end

    assign bus.state        = state_reg;
    assign bus.score        = score_reg;
    assign bus.candies_left = left_reg;
    assign bus.steps        = steps_reg;
    assign bus.won          = won_reg;
    assign bus.lost         = lost_reg;
    assign bus.timeout      = timeout_reg;
    assign bus.game_over    = over_reg;
endmodule

// File: tb/tb_pacman_game_monitor.sv
// Directed bench for pacman_game_monitor: a session-level reference model is
// compared every cycle, plus hand-computed checkpoints along the way.
module tb_pacman_game_monitor;
    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 8;
    localparam int SCORE_W   = 10;
    localparam int CANDY_PTS = 10;
    localparam int STEP_W    = 8;
    localparam int MAX_STEPS = 4;
    localparam int SCORE_CAP = (1 << SCORE_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pacman_game_monitor_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCORE_W(SCORE_W), .STEP_W(STEP_W)) bus ();

    pacman_game_monitor #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCORE_W(SCORE_W), .CANDY_PTS(CANDY_PTS),
        .STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Session-level reference: 0 idle, 1 playing, 2 won, 3 lost.
    int          m_state, m_score, m_left, m_steps, m_prev_count;
    bit          m_timeout;
    logic [15:0] m_prev_pos;
    int          cur;
    int          gained;
    bit          moved;

    assign cur    = $countones(bus.candies);
    assign gained = (cur < m_prev_count) ? (m_prev_count - cur) * CANDY_PTS : 0;
    assign moved  = ({bus.pacman_x, bus.pacman_y} != m_prev_pos);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_score <= 0; m_left <= 0; m_steps <= 0;
            m_prev_count <= 0; m_timeout <= 1'b0; m_prev_pos <= '0;
        end else begin
            m_left <= cur;
            if (m_state == 1) begin
                m_score      <= (m_score + gained > SCORE_CAP) ? SCORE_CAP : m_score + gained;
                m_prev_count <= cur;
                m_prev_pos   <= {bus.pacman_x, bus.pacman_y};
                if (moved) m_steps <= m_steps + 1;
                if (bus.catch) begin
                    m_state <= 3; m_timeout <= 1'b0;
                end else if (cur == 0) begin
                    m_state <= 2;
                end else if (moved && m_steps + 1 == MAX_STEPS) begin
                    m_state <= 3; m_timeout <= 1'b1;
                end
            end else if (bus.start) begin
                m_state <= 1; m_score <= 0; m_steps <= 0; m_timeout <= 1'b0;
                m_prev_count <= cur;
                m_prev_pos   <= {bus.pacman_x, bus.pacman_y};
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("state",        64'(bus.state),        64'(m_state));
        check("score",        64'(bus.score),        64'(m_score));
        check("candies_left", 64'(bus.candies_left), 64'(m_left));
        check("steps",        64'(bus.steps),        64'(m_steps));
        check("won",          64'(bus.won),          64'(m_state == 2));
        check("lost",         64'(bus.lost),         64'(m_state == 3));
        check("timeout",      64'(bus.timeout),      64'(m_timeout));
        check("game_over",    64'(bus.game_over),    64'(m_state >= 2));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    logic [63:0] map31  = 64'h0000_0000_7FFF_FFFF;
    logic [63:0] map64  = '1;

    initial begin
        bus.start = 1'b0; bus.pacman_x = 8'h01; bus.pacman_y = 8'h01;
        bus.candies = '0; bus.catch = 1'b0;
        step(2);
        check("reset_state", 64'(bus.state), 64'd0);
        check("reset_score", 64'(bus.score), 64'd0);
        check("reset_over",  64'(bus.game_over), 64'd0);
        rst = 1'b0;
        bus.candies = map31;
        step(1);
        check("left_31", 64'(bus.candies_left), 64'd31);
        pulse_start();
        check("play_state", 64'(bus.state), 64'd1);
        check("play_steps", 64'(bus.steps), 64'd0);

        // One candy per cycle, then two at once, then a reload of one bit.
        bus.candies[0][0] = 1'b0; step(1); check("score_10", 64'(bus.score), 64'd10);
        bus.candies[0][1] = 1'b0; step(1); check("score_20", 64'(bus.score), 64'd20);
        bus.candies[0][2] = 1'b0; step(1); check("score_30", 64'(bus.score), 64'd30);
        bus.candies[0][3] = 1'b0; bus.candies[0][4] = 1'b0;
        step(1); check("score_50", 64'(bus.score), 64'd50);
        bus.candies[0][3] = 1'b1; step(1); check("reload_50", 64'(bus.score), 64'd50);

        // Asynchronous abort mid-session, then a clean restart on the 27-candy map.
        rst = 1'b1; #1;
        check("abort_state", 64'(bus.state), 64'd0);
        check("abort_score", 64'(bus.score), 64'd0);
        step(1); rst = 1'b0;
        pulse_start();
        step(2);
        check("restart_score", 64'(bus.score), 64'd0);

        // Reload to 31 during play awards nothing; emptying it scores 310 and wins.
        bus.candies = map31; step(1); check("reload_score", 64'(bus.score), 64'd0);
        bus.candies = '0; step(1);
        check("won_state", 64'(bus.state), 64'd2);
        check("won_score", 64'(bus.score), 64'd310);
        check("won_flag",  64'(bus.won), 64'd1);
        step(3); check("won_frozen", 64'(bus.score), 64'd310);

        // Last candy and catch together: lost, and that candy still scores.
        bus.candies = map31; pulse_start(); step(1);
        bus.candies = 64'h1; step(1); check("pre_catch", 64'(bus.score), 64'd300);
        bus.candies = '0; bus.catch = 1'b1; step(1);
        check("catch_state",   64'(bus.state), 64'd3);
        check("catch_timeout", 64'(bus.timeout), 64'd0);
        check("catch_score",   64'(bus.score), 64'd310);
        bus.catch = 1'b0;

        // Saturation across a reload, and start ignored during play.
        bus.candies = map64; pulse_start();
        bus.candies = 64'h1; step(1); check("sat_630", 64'(bus.score), 64'd630);
        bus.candies = map64; step(1);
        bus.candies = 64'h1; step(1); check("sat_cap", 64'(bus.score), 64'(SCORE_CAP));
        pulse_start(); check("start_ignored", 64'(bus.score), 64'(SCORE_CAP));
        bus.catch = 1'b1; step(1); bus.catch = 1'b0;

        // Step limit: idle position does not count; the fourth move times out.
        bus.candies = map31; pulse_start();
        step(10); check("hold_steps", 64'(bus.steps), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            bus.pacman_x = 8'(1 << k); step(1);
        end
        check("steps_3", 64'(bus.steps), 64'd3);
        check("steps_3_state", 64'(bus.state), 64'd1);
        bus.pacman_x = 8'h10; step(1);
        check("to_state",   64'(bus.state), 64'd3);
        check("to_timeout", 64'(bus.timeout), 64'd1);
        check("to_steps",   64'(bus.steps), 64'd4);

        // Last candy coinciding with the step limit is a win.
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            bus.pacman_y = 8'(2 << k); step(1);
        end
        bus.pacman_y = 8'h80; bus.candies = '0; step(1);
        check("tie_state",   64'(bus.state), 64'd2);
        check("tie_timeout", 64'(bus.timeout), 64'd0);
        check("tie_steps",   64'(bus.steps), 64'd4);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
